// File: rtl/detect_pkg.sv
// detect_pkg: shared "101" detector state type and next-state function
package detect_pkg;
  localparam int DET_STATE_W = 2;
  typedef enum logic [DET_STATE_W-1:0] {S0 = 2'b00, S1 = 2'b01, S2 = 2'b10, S3 = 2'b11} det_state_t;
  // S1: last bit 1, S2: last bits "10", S3: last bits "101" (match)
  function automatic det_state_t det_next(det_state_t s, logic b);
    return b ? ((s == S2) ? S3 : S1) : ((s == S1 || s == S3) ? S2 : S0);
  endfunction
endpackage

// File: rtl/rr_arbiter.sv
// rr_arbiter: round-robin pick of first requester at or after ptr
//   req   : request vector
//   ptr   : highest-priority index this cycle
//   grant : one-hot-or-zero grant
//   idx   : encoded index of the granted requester
//   any   : some requester was granted
module rr_arbiter #(
  parameter int NUM_CH = 4,
  localparam int CH_W = $clog2(NUM_CH)
) (
  input  logic [NUM_CH-1:0] req,
  input  logic [CH_W-1:0]   ptr,
  output logic [NUM_CH-1:0] grant,
  output logic [CH_W-1:0]   idx,
  output logic              any
);
  int c;
  always_comb begin
    grant = '0;
    idx = '0;
    any = 1'b0;
    c = 0;
    for (int k = 0; k < NUM_CH; k++) begin
      c = (int'(ptr) + k) % NUM_CH;
      if (!any && req[c]) begin
        grant[c] = 1'b1;
        idx = CH_W'(c);
        any = 1'b1;
      end
    end
  end
endmodule

// File: rtl/detect_rr_sched.sv
// detect_rr_sched: one shared "101" detector time-multiplexed over NUM_CH streams
//   clock, reset        : clock and synchronous active-high reset
//   ch_valid/bit/clear  : per-channel request, serial bit, context+counter clear
//   ch_grant            : combinational one-hot grant, bit consumed this cycle
//   res_valid/ch/match  : registered result of the previous cycle's grant
//   hit_cnt             : saturating per-channel match counters, channel i at [i*CNT_W +: CNT_W]
module detect_rr_sched
  import detect_pkg::*;
#(
  parameter int NUM_CH = 4,
  parameter int CNT_W = 8,
  localparam int CH_W = $clog2(NUM_CH)
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic [NUM_CH-1:0]       ch_valid,
  input  logic [NUM_CH-1:0]       ch_bit,
  input  logic [NUM_CH-1:0]       ch_clear,
  output logic [NUM_CH-1:0]       ch_grant,
  output logic                    res_valid,
  output logic [CH_W-1:0]         res_ch,
  output logic                    res_match,
  output logic [NUM_CH*CNT_W-1:0] hit_cnt
);
  logic [CH_W-1:0] rr_ptr, g;
  logic any, match;
  logic [NUM_CH-1:0] eligible;
  det_state_t ctx [NUM_CH];
  det_state_t nxt;
  logic [CNT_W-1:0] cnt [NUM_CH];

  // clear wins over a pending bit; nothing is granted during reset
  assign eligible = reset ? '0 : ch_valid & ~ch_clear;

  rr_arbiter #(.NUM_CH(NUM_CH)) u_arb (
    .req(eligible),
    .ptr(rr_ptr),
    .grant(ch_grant),
    .idx(g),
    .any(any)
  );

  assign nxt = det_next(ctx[g], ch_bit[g]);
  assign match = nxt == S3;

  always_ff @(posedge clock) begin
    if (reset) begin
      rr_ptr <= '0;
      res_valid <= 1'b0;
      res_ch <= '0;
      res_match <= 1'b0;
      for (int i = 0; i < NUM_CH; i++) begin
        ctx[i] <= S0;
        cnt[i] <= '0;
      end
    end else begin
      res_valid <= any;
      if (any) begin
        rr_ptr <= (g == CH_W'(NUM_CH - 1)) ? '0 : g + CH_W'(1);
        res_ch <= g;
        res_match <= match;
        ctx[g] <= nxt;
        if (match && cnt[g] != '1) cnt[g] <= cnt[g] + CNT_W'(1);
      end
      // a cleared channel is never the granted one, so these cannot collide
      for (int i = 0; i < NUM_CH; i++) begin
        if (ch_clear[i]) begin
          ctx[i] <= S0;
          cnt[i] <= '0;
        end
      end
    end
  end

  for (genvar i = 0; i < NUM_CH; i++) begin : g_hit
    assign hit_cnt[i*CNT_W +: CNT_W] = cnt[i];
  end
endmodule

// File: tb/tb_detect_rr_sched.sv
// tb_detect_rr_sched: scoreboard bench with a bit-history reference model
module tb_detect_rr_sched;
  localparam int NUM_CH = 4;
  localparam int CNT_W = 8;
  localparam int CNT_MAX = (1 << CNT_W) - 1;

  logic clock = 1'b0;
  logic reset = 1'b1;
  logic [NUM_CH-1:0] ch_valid = '0, ch_bit = '0, ch_clear = '0;
  logic [NUM_CH-1:0] ch_grant;
  logic res_valid, res_match;
  logic [1:0] res_ch;
  logic [NUM_CH*CNT_W-1:0] hit_cnt;

  detect_rr_sched #(.NUM_CH(NUM_CH), .CNT_W(CNT_W)) dut (
    .clock(clock),
    .reset(reset),
    .ch_valid(ch_valid),
    .ch_bit(ch_bit),
    .ch_clear(ch_clear),
    .ch_grant(ch_grant),
    .res_valid(res_valid),
    .res_ch(res_ch),
    .res_match(res_match),
    .hit_cnt(hit_cnt)
  );

  always #5 clock = ~clock;

  typedef struct {int ch; int m;} exp_t;
  exp_t q[$];
  int tests = 0, fails = 0;
  // reference model: last three consumed bits since clear, count of them, hit totals, pointer
  int hist [NUM_CH];
  int len [NUM_CH];
  int hits [NUM_CH];
  int ptr = 0;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s got=%0d exp=%0d at %0t", name, got, exp, $time);
    end
  endtask

  function automatic int hit(int i);
    return int'(hit_cnt[i*CNT_W +: CNT_W]);
  endfunction

  task automatic model_reset();
    for (int i = 0; i < NUM_CH; i++) begin
      hist[i] = 0;
      len[i] = 0;
      hits[i] = 0;
    end
    ptr = 0;
    q.delete();
  endtask

  task automatic do_reset();
    @(negedge clock);
    reset = 1'b1;
    ch_valid = 4'b1111;
    ch_bit = '0;
    ch_clear = '0;
    #1;
    chk("grant_in_reset", ch_grant, 0);
    model_reset();
  endtask

  task automatic cycle(input logic [NUM_CH-1:0] v, input logic [NUM_CH-1:0] b, input logic [NUM_CH-1:0] c);
    int g;
    int m;
    @(negedge clock);
    reset = 1'b0;
    ch_valid = v;
    ch_bit = b;
    ch_clear = c;
    #1;
    g = -1;
    for (int k = 0; k < NUM_CH; k++) begin
      int cc;
      cc = (ptr + k) % NUM_CH;
      if (g < 0 && v[cc] && !c[cc]) g = cc;
    end
    chk("grant", ch_grant, (g < 0) ? 0 : (1 << g));
    if (g >= 0) begin
      hist[g] = ((hist[g] << 1) | int'(b[g])) & 7;
      len[g]++;
      m = (len[g] >= 3 && hist[g] == 5) ? 1 : 0;
      if (m == 1 && hits[g] < CNT_MAX) hits[g]++;
      q.push_back('{ch: g, m: m});
      ptr = (g + 1) % NUM_CH;
    end
    for (int i = 0; i < NUM_CH; i++) begin
      if (c[i]) begin
        hist[i] = 0;
        len[i] = 0;
        hits[i] = 0;
      end
    end
  endtask

  task automatic settle();
    @(posedge clock);
    #2;
  endtask

  // monitor: every edge, either the pending expected result appears or the output is idle
  always @(posedge clock) begin
    exp_t e;
    #1;
    if (q.size() > 0) begin
      e = q.pop_front();
      chk("res_valid", res_valid, 1);
      chk("res_ch", res_ch, e.ch);
      chk("res_match", res_match, e.m);
    end else begin
      chk("res_idle", res_valid, 0);
    end
    for (int i = 0; i < NUM_CH; i++) chk("hit_cnt", hit(i), hits[i]);
  end

  initial begin
    model_reset();
    repeat (2) @(negedge clock);
    // ch0 alone: 1,0,1 -> one match
    cycle(4'b0001, 4'b0001, 4'b0000);
    cycle(4'b0001, 4'b0000, 4'b0000);
    cycle(4'b0001, 4'b0001, 4'b0000);
    cycle(4'b0000, 4'b0000, 4'b0000);
    settle();
    chk("ch0_single_hit", hit(0), 1);
    // all valid: strict rotation, ch1 fed 1,0,1 over its slots
    do_reset();
    for (int r = 0; r < 3; r++) begin
      logic [NUM_CH-1:0] b;
      b = 4'($urandom);
      b[1] = (r != 1);
      for (int s = 0; s < NUM_CH; s++) cycle(4'b1111, b, 4'b0000);
    end
    cycle(4'b1111, 4'b0000, 4'b0000);
    settle();
    chk("ch1_isolated_hit", hit(1), 1);
    // overlap: 1,0,1,0,1 -> two matches
    do_reset();
    for (int k = 0; k < 5; k++) cycle(4'b0001, (k % 2 == 0) ? 4'b0001 : 4'b0000, 4'b0000);
    cycle(4'b0000, 4'b0000, 4'b0000);
    settle();
    chk("ch0_overlap_hits", hit(0), 2);
    // saturation on ch2
    do_reset();
    for (int k = 0; k < 300; k++) begin
      cycle(4'b0100, 4'b0100, 4'b0000);
      cycle(4'b0100, 4'b0000, 4'b0000);
      cycle(4'b0100, 4'b0100, 4'b0000);
    end
    cycle(4'b0000, 4'b0000, 4'b0000);
    settle();
    chk("ch2_saturated", hit(2), CNT_MAX);
    // clear while ch1 sits in S2: not granted, then fresh context
    do_reset();
    cycle(4'b0010, 4'b0010, 4'b0000);
    cycle(4'b0010, 4'b0000, 4'b0000);
    cycle(4'b0010, 4'b0010, 4'b0010);
    cycle(4'b0010, 4'b0010, 4'b0000);
    cycle(4'b0000, 4'b0000, 4'b0000);
    settle();
    chk("ch1_after_clear", hit(1), 0);
    // reset right after a grant discards state and restarts at ch0
    cycle(4'b1111, 4'b0000, 4'b0000);
    cycle(4'b1111, 4'b0000, 4'b0000);
    do_reset();
    cycle(4'b1111, 4'b0000, 4'b0000);
    chk("grant_ch0_after_reset", ch_grant, 4'b0001);
    // randomized traffic with occasional clears and resets
    for (int k = 0; k < 800; k++) begin
      if ($urandom_range(0, 99) == 0) do_reset();
      else cycle(4'($urandom), 4'($urandom), ($urandom_range(0, 7) == 0) ? 4'($urandom) : 4'b0000);
    end
    cycle(4'b0000, 4'b0000, 4'b0000);
    settle();
    chk("queue_drained", q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
